fp_minmax_reduce: RTL and testbench

Streaming IEEE-754 min/max reduction unit, parametrised in exponent and mantissa width (FP32 default, FP16 by parameter).
- Accepts a vector of LEN operands over a valid/ready input stream.
- Returns the minimum or maximum (selectable per job) together with the index of the winning element.
- Sits beside the combinational FP compare/min/max ALU ops and serves vector reduce instructions without tying up the ALU.

---
 rtl/fp_minmax_pkg.sv | 41 ++++
 rtl/fp_cmp_lt.sv | 23 ++
 rtl/fp_minmax_reduce.sv | 127 ++++++++++++
 tb/tb_fp_minmax_reduce.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_minmax_pkg.sv
// Shared types and IEEE-754 field helpers for the FP min/max reduction unit.
// Helpers take fields zero-extended to FMAX bits so one package serves any EXP_W/MAN_W.
package fp_minmax_pkg;

   localparam int FMAX = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic MODE_MIN = 1'b0;
   localparam logic MODE_MAX = 1'b1;

   function automatic logic [FMAX-1:0] ones_mask(input int w);
      return (FMAX'(1) << w) - FMAX'(1);
   endfunction

   // Sign 0, exponent all ones, only the mantissa MSB set.
   function automatic logic [FMAX-1:0] canon_qnan(input int exp_w, input int man_w);
      return (ones_mask(exp_w) << man_w) | (FMAX'(1) << (man_w - 1));
   endfunction

   function automatic logic is_nan(input logic [FMAX-1:0] exp_f,
                                   input logic [FMAX-1:0] man_f,
                                   input int exp_w);
      return (exp_f == ones_mask(exp_w)) && (man_f != '0);
   endfunction

   function automatic logic is_zero(input logic [FMAX-1:0] exp_f,
                                    input logic [FMAX-1:0] man_f);
      return (exp_f == '0) && (man_f == '0);
   endfunction

   function automatic logic is_subnormal(input logic [FMAX-1:0] exp_f,
                                         input logic [FMAX-1:0] man_f);
      return (exp_f == '0) && (man_f != '0);
   endfunction

endpackage

// File: rtl/fp_cmp_lt.sv
// Combinational IEEE-754 "a < b" on bit patterns: -0 < +0, infinities ordinary.
// Inputs are assumed NaN-free; the caller filters NaNs.
module fp_cmp_lt #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int DW    = 1 + EXP_W + MAN_W
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          a_lt_b
);

   always_comb begin
      a_lt_b = 1'b0;
      if (a[DW-1] != b[DW-1])
         a_lt_b = a[DW-1];
      else if (a[DW-1])
         a_lt_b = a[DW-2:0] > b[DW-2:0];
      else
         a_lt_b = a[DW-2:0] < b[DW-2:0];
   end

endmodule

// File: rtl/fp_minmax_reduce.sv
// Streaming FP min/max reduction over LEN elements, returning value, winning index and NaN flag.
// Macro FP_MINMAX_DAZ_EN flushes subnormal inputs to same-signed zero before compare and storage.
module fp_minmax_reduce
   import fp_minmax_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   parameter  int CNT_W = 8,
   localparam int DW    = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic [CNT_W-1:0] out_index,
   output logic             nan_flag,
   output logic             busy
);

   localparam logic [DW-1:0] QNAN = DW'(canon_qnan(EXP_W, MAN_W));

   state_t           state, state_nxt;
   logic             mode_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] elem_cnt;
   logic             have_val;
   logic [DW-1:0]    x_eff;
   logic             x_nan;
   logic             better;
   logic             xfer;
   logic             last_elem;
   logic [DW-1:0]    cmp_a, cmp_b;

   assign x_nan = is_nan(FMAX'(in_data[DW-2 -: EXP_W]), FMAX'(in_data[MAN_W-1:0]), EXP_W);

`ifdef FP_MINMAX_DAZ_EN
   always_comb begin
      x_eff = in_data;
      if (is_subnormal(FMAX'(in_data[DW-2 -: EXP_W]), FMAX'(in_data[MAN_W-1:0])))
         x_eff = {in_data[DW-1], {(DW-1){1'b0}}};
   end
`else
   assign x_eff = in_data;
`endif

   // min replaces on x < acc, max on acc < x; strict compare keeps the earliest tie.
   assign cmp_a = (mode_q == MODE_MAX) ? out_data : x_eff;
   assign cmp_b = (mode_q == MODE_MAX) ? x_eff    : out_data;

   fp_cmp_lt #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cmp (
      .a      (cmp_a),
      .b      (cmp_b),
      .a_lt_b (better)
   );

   assign xfer      = (state == ACCUM) && in_valid;
   assign last_elem = (elem_cnt == len_q - CNT_W'(1));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = (len == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && last_elem)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulator starts as qNaN so an all-NaN or empty job returns it untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= MODE_MIN;
         len_q     <= '0;
         elem_cnt  <= '0;
         have_val  <= 1'b0;
         nan_flag  <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
      end else if (state == IDLE && start) begin
         mode_q    <= mode;
         len_q     <= len;
         elem_cnt  <= '0;
         have_val  <= 1'b0;
         nan_flag  <= 1'b0;
         out_data  <= QNAN;
         out_index <= '0;
      end else if (xfer) begin
         elem_cnt <= elem_cnt + CNT_W'(1);
         if (x_nan) begin
            nan_flag <= 1'b1;
         end else if (!have_val || better) begin
            out_data  <= x_eff;
            out_index <= elem_cnt;
            have_val  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Scoreboard bench for fp_minmax_reduce: FP32 instance for the main plan, FP16 instance for width check.
module tb_fp_minmax_reduce;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start, mode, in_valid, out_ready;
   logic [7:0]  len;
   logic [31:0] in_data;
   logic        in_ready, out_valid, nan_flag, busy;
   logic [31:0] out_data;
   logic [7:0]  out_index;

   logic        h_start, h_mode, h_in_valid, h_out_ready;
   logic [7:0]  h_len;
   logic [15:0] h_in_data;
   logic        h_in_ready, h_out_valid, h_nan_flag, h_busy;
   logic [15:0] h_out_data;
   logic [7:0]  h_out_index;

   always #5 clk = ~clk;

   fp_minmax_reduce dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .nan_flag(nan_flag), .busy(busy)
   );

   fp_minmax_reduce #(.EXP_W(5), .MAN_W(10), .CNT_W(8)) dut16 (
      .clk(clk), .rst(rst), .start(h_start), .mode(h_mode), .len(h_len),
      .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .out_data(h_out_data),
      .out_index(h_out_index), .nan_flag(h_nan_flag), .busy(h_busy)
   );

   typedef struct {
      logic [31:0] d;
      logic [7:0]  i;
      logic        n;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] vec[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: every accepted result is popped and compared against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got %h with empty scoreboard", out_data);
         end else begin
            e = sb.pop_front();
            check("out_data",  64'(out_data),  64'(e.d));
            check("out_index", 64'(out_index), 64'(e.i));
            check("nan_flag",  64'(nan_flag),  64'(e.n));
         end
      end
   end

   task automatic reset_check(input string name);
      check(name, {out_valid, in_ready, busy, nan_flag, out_data, out_index}, 64'd0);
   endtask

   task automatic send_job(input logic m, input int n, input logic [31:0] ed,
                           input logic [7:0] ei, input logic en,
                           input bit gaps, input bit hold, input bit poke);
      int i;
      int guard;
      bit took;
      sb.push_back('{ed, ei, en});
      out_ready = !hold;
      @(posedge clk); #1;
      start = 1'b1; mode = m; len = 8'(n);
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0)
         check("len0_latency", 64'(out_valid), 64'd1);
      else
         check("accum_entry", {out_valid, in_ready, busy}, 64'b011);
      i = 0;
      guard = 0;
      while (i < n && guard < 200) begin
         start = poke && (i == 1);
         if (poke) begin
            mode = ~m;
            len  = 8'd1;
         end
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = vec[i];
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took) i++;
         guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (n > 0) begin
         check("feed_count", 64'(i), 64'(n));
         check("out_latency", 64'(out_valid), 64'd1);
      end
      if (hold) begin
         for (int k = 0; k < 5; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("hold_stable", {out_valid, in_ready, out_data, out_index, nan_flag},
                  {1'b1, 1'b0, ed, ei, en});
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      guard = 0;
      while (busy && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("return_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] daz_exp;
      start = 0; mode = 0; len = 0; in_valid = 0; in_data = 0; out_ready = 1;
      h_start = 0; h_mode = 0; h_len = 0; h_in_valid = 0; h_in_data = 0; h_out_ready = 1;
      #12;
      reset_check("reset_state");
      @(posedge clk); #1;
      rst = 1'b0;

      vec = '{32'h3F800000, 32'hC0000000, 32'h40600000, 32'h00000000};
      send_job(1'b0, 4, 32'hC0000000, 8'd1, 1'b0, 0, 0, 0);

      vec = '{32'h7FC00000, 32'h3F800000, 32'h40600000};
      send_job(1'b1, 3, 32'h40600000, 8'd2, 1'b1, 0, 0, 0);

      vec = '{32'h00000000, 32'h80000000};
      send_job(1'b0, 2, 32'h80000000, 8'd1, 1'b0, 0, 0, 0);

      vec = '{32'h3F800000, 32'h3F800000};
      send_job(1'b1, 2, 32'h3F800000, 8'd0, 1'b0, 0, 0, 0);

      send_job(1'b0, 0, 32'h7FC00000, 8'd0, 1'b0, 0, 0, 0);

      vec = '{32'h7F800001, 32'hFFC00000};
      send_job(1'b0, 2, 32'h7FC00000, 8'd0, 1'b1, 0, 0, 0);

      vec = '{32'hFF800000, 32'hC0000000, 32'h7F800000, 32'h3F800000};
      send_job(1'b1, 4, 32'h7F800000, 8'd2, 1'b0, 1, 1, 0);

      vec = '{32'h40000000, 32'h3F800000, 32'hBF800000};
      send_job(1'b0, 3, 32'hBF800000, 8'd2, 1'b0, 0, 0, 1);

      // Reset after two of four elements: partial job must vanish.
      @(posedge clk); #1;
      start = 1'b1; mode = 1'b0; len = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1; in_data = 32'h40000000;
      @(posedge clk); #1;
      in_data = 32'h3F800000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      reset_check("midjob_reset");
      @(posedge clk); #1;
      rst = 1'b0;

      vec = '{32'h80000000, 32'h00000000, 32'hC1200000, 32'hC1200000};
      send_job(1'b0, 4, 32'hC1200000, 8'd2, 1'b0, 1, 0, 0);

`ifdef FP_MINMAX_DAZ_EN
      daz_exp = 32'h80000000;
`else
      daz_exp = 32'h80000001;
`endif
      vec = '{32'h00000001, 32'h80000001};
      send_job(1'b0, 2, daz_exp, 8'd1, 1'b0, 0, 0, 0);

      @(posedge clk); #1;
      h_start = 1'b1; h_mode = 1'b0; h_len = 8'd2;
      @(posedge clk); #1;
      h_start = 1'b0;
      h_in_valid = 1'b1; h_in_data = 16'h3C00;
      @(posedge clk); #1;
      h_in_data = 16'hBC00;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      check("fp16_min", {h_out_valid, h_out_data, h_out_index, h_nan_flag},
            {1'b1, 16'hBC00, 8'd1, 1'b0});
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
